store_align_queue: RTL and testbench

//  Parametrised store path between the MEM stage and data memory. Accepts byte, half, word or
//  (XLEN=64) double stores at any byte address, lane-aligns data and byte-enables, and splits

---
 rtl/store_align_queue.sv | 128 ++++++++++++
 tb/tb_store_align_queue.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_align_queue.sv
// Store path between MEM stage and data memory: lane-aligns byte/half/word/double
// stores, splits word-boundary crossings into two beats and buffers beats in a FIFO.
module store_align_queue #(
    parameter int XLEN      = 32,
    parameter int ADDR_W    = 32,
    parameter int DEPTH     = 4,
    parameter int SPLIT_MIS = 1,
    localparam int NB       = XLEN / 8,
    localparam int OFFW     = $clog2(NB),
    localparam int CW       = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [XLEN-1:0]   st_data,
    input  logic [1:0]        st_size,
    output logic              dm_valid,
    input  logic              dm_ready,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [XLEN-1:0]   dm_wdata,
    output logic [NB-1:0]     dm_we,
    output logic              misalign_err,
    output logic [CW-1:0]     count
);

    localparam int PW = $clog2(DEPTH);

    logic [ADDR_W-1:0] fifo_addr_r [DEPTH];
    logic [XLEN-1:0]   fifo_data_r [DEPTH];
    logic [NB-1:0]     fifo_we_r   [DEPTH];
    logic [PW-1:0]     wr_ptr_r;
    logic [PW-1:0]     rd_ptr_r;
    logic [CW-1:0]     count_r;
    logic              misalign_err_r;

    logic [OFFW-1:0]   off_s;
    logic [4:0]        sz_bytes_s;
    logic [4:0]        end_s;
    logic [NB-1:0]     lane_mask_s;
    logic [XLEN-1:0]   data_keep_s;
    logic [2*XLEN-1:0] wide_data_s;
    logic [2*NB-1:0]   wide_we_s;
    logic [ADDR_W-1:0] word_addr_s;
    logic [PW-1:0]     wr_ptr_nxt_s;
    logic              cross_s;
    logic              drop_s;
    logic              accept_s;
    logic              pop_s;
    logic [1:0]        push_n_s;

    // Room for a worst-case split store; depends on registered count only.
    assign st_ready = (CW'(DEPTH) - count_r) >= CW'(2);

    // Request decode: size mask, lane shift across a double-width window, beat count.
    always_comb begin
        off_s = st_addr[OFFW-1:0];
        case (st_size)
            2'd0:    sz_bytes_s = 5'd1;
            2'd1:    sz_bytes_s = 5'd2;
            2'd2:    sz_bytes_s = 5'd4;
            2'd3:    sz_bytes_s = 5'd8;
            default: sz_bytes_s = 5'd1;
        endcase
        for (int i = 0; i < NB; i++) begin
            lane_mask_s[i]         = (i < int'(sz_bytes_s));
            data_keep_s[8*i +: 8]  = st_data[8*i +: 8] & {8{lane_mask_s[i]}};
        end
        end_s        = 5'(off_s) + sz_bytes_s;
        cross_s      = end_s > 5'(NB);
        drop_s       = (cross_s && (SPLIT_MIS == 0)) || ((XLEN == 32) && (st_size == 2'd3));
        word_addr_s  = {st_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
        // Upper half of the shifted window is exactly the second beat of a split.
        wide_data_s  = {{XLEN{1'b0}}, data_keep_s} << {off_s, 3'b000};
        wide_we_s    = {{NB{1'b0}}, lane_mask_s} << off_s;
        wr_ptr_nxt_s = wr_ptr_r + PW'(1);
        accept_s     = st_valid && st_ready;
        pop_s        = (count_r != CW'(0)) && dm_ready;
        if (!accept_s || drop_s) begin
            push_n_s = 2'd0;
        end else if (cross_s) begin
            push_n_s = 2'd2;
        end else begin
            push_n_s = 2'd1;
        end
    end

    // Beat FIFO storage, pointers, occupancy and the drop pulse.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_addr_r[i] <= {ADDR_W{1'b0}};
                fifo_data_r[i] <= {XLEN{1'b0}};
                fifo_we_r[i]   <= {NB{1'b0}};
            end
            wr_ptr_r       <= {PW{1'b0}};
            rd_ptr_r       <= {PW{1'b0}};
            count_r        <= {CW{1'b0}};
            misalign_err_r <= 1'b0;
        end else begin
            if (push_n_s != 2'd0) begin
                fifo_addr_r[wr_ptr_r] <= word_addr_s;
                fifo_data_r[wr_ptr_r] <= wide_data_s[XLEN-1:0];
                fifo_we_r[wr_ptr_r]   <= wide_we_s[NB-1:0];
            end
            if (push_n_s == 2'd2) begin
                fifo_addr_r[wr_ptr_nxt_s] <= word_addr_s + ADDR_W'(NB);
                fifo_data_r[wr_ptr_nxt_s] <= wide_data_s[2*XLEN-1:XLEN];
                fifo_we_r[wr_ptr_nxt_s]   <= wide_we_s[2*NB-1:NB];
            end
            wr_ptr_r <= wr_ptr_r + PW'(push_n_s);
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            count_r        <= count_r + CW'(push_n_s) - CW'(pop_s);
            misalign_err_r <= accept_s && drop_s;
        end
    end

    assign dm_valid     = count_r != CW'(0);
    assign dm_addr      = fifo_addr_r[rd_ptr_r];
    assign dm_wdata     = fifo_data_r[rd_ptr_r];
    assign dm_we        = fifo_we_r[rd_ptr_r];
    assign misalign_err = misalign_err_r;
    assign count        = count_r;

endmodule

// File: tb/tb_store_align_queue.sv
// Directed + scoreboard bench for store_align_queue: a split-enabled 32-bit
// instance, a no-split 32-bit instance and a 64-bit instance.
module tb_store_align_queue;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  we;
    } beat_t;

    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    logic        a_st_valid, a_st_ready, a_dm_valid, a_dm_ready, a_err;
    logic [31:0] a_st_addr, a_st_data, a_dm_addr, a_dm_wdata;
    logic [1:0]  a_st_size;
    logic [3:0]  a_dm_we;
    logic [2:0]  a_count;

    logic        b_st_valid, b_st_ready, b_dm_valid, b_dm_ready, b_err;
    logic [31:0] b_st_addr, b_st_data, b_dm_addr, b_dm_wdata;
    logic [1:0]  b_st_size;
    logic [3:0]  b_dm_we;
    logic [2:0]  b_count;

    logic        c_st_valid, c_st_ready, c_dm_valid, c_dm_ready, c_err;
    logic [31:0] c_st_addr, c_dm_addr;
    logic [63:0] c_st_data, c_dm_wdata;
    logic [1:0]  c_st_size;
    logic [7:0]  c_dm_we;
    logic [2:0]  c_count;

    int    errors = 0;
    int    checks = 0;
    beat_t exp_q[$];
    beat_t a_e;

    store_align_queue #(.XLEN(32), .ADDR_W(32), .DEPTH(4), .SPLIT_MIS(1)) dut (
        .clk(clk), .nrst(nrst), .st_valid(a_st_valid), .st_ready(a_st_ready),
        .st_addr(a_st_addr), .st_data(a_st_data), .st_size(a_st_size),
        .dm_valid(a_dm_valid), .dm_ready(a_dm_ready), .dm_addr(a_dm_addr),
        .dm_wdata(a_dm_wdata), .dm_we(a_dm_we), .misalign_err(a_err), .count(a_count));

    store_align_queue #(.XLEN(32), .ADDR_W(32), .DEPTH(4), .SPLIT_MIS(0)) dut_ns (
        .clk(clk), .nrst(nrst), .st_valid(b_st_valid), .st_ready(b_st_ready),
        .st_addr(b_st_addr), .st_data(b_st_data), .st_size(b_st_size),
        .dm_valid(b_dm_valid), .dm_ready(b_dm_ready), .dm_addr(b_dm_addr),
        .dm_wdata(b_dm_wdata), .dm_we(b_dm_we), .misalign_err(b_err), .count(b_count));

    store_align_queue #(.XLEN(64), .ADDR_W(32), .DEPTH(4), .SPLIT_MIS(1)) dut64 (
        .clk(clk), .nrst(nrst), .st_valid(c_st_valid), .st_ready(c_st_ready),
        .st_addr(c_st_addr), .st_data(c_st_data), .st_size(c_st_size),
        .dm_valid(c_dm_valid), .dm_ready(c_dm_ready), .dm_addr(c_dm_addr),
        .dm_wdata(c_dm_wdata), .dm_we(c_dm_we), .misalign_err(c_err), .count(c_count));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Byte-by-byte reference: each store byte lands in lane off+k of beat0 or beat1.
    task automatic push_model(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size);
        beat_t b0, b1;
        logic  used1;
        int    sz, off, lane;
        sz      = 1 << size;
        off     = int'(addr[1:0]);
        used1   = 1'b0;
        b0.addr = {addr[31:2], 2'b00};
        b0.data = 32'd0;
        b0.we   = 4'd0;
        b1.addr = b0.addr + 32'd4;
        b1.data = 32'd0;
        b1.we   = 4'd0;
        for (int k = 0; k < sz; k++) begin
            lane = off + k;
            if (lane < 4) begin
                b0.data[8*lane +: 8] = data[8*k +: 8];
                b0.we[lane]          = 1'b1;
            end else begin
                b1.data[8*(lane-4) +: 8] = data[8*k +: 8];
                b1.we[lane-4]            = 1'b1;
                used1                    = 1'b1;
            end
        end
        exp_q.push_back(b0);
        if (used1) exp_q.push_back(b1);
    endtask

    task automatic store_a(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size);
        logic acc;
        int   n;
        acc        = 1'b0;
        n          = 0;
        a_st_valid = 1'b1;
        a_st_addr  = addr;
        a_st_data  = data;
        a_st_size  = size;
        while (!acc && n < 200) begin
            acc = a_st_ready;
            if (acc) push_model(addr, data, size);
            @(posedge clk); #1;
            n++;
        end
        a_st_valid = 1'b0;
        chk("a_accept", 64'(acc), 64'd1);
    endtask

    task automatic drain_a();
        int n;
        n          = 0;
        a_dm_ready = 1'b1;
        while (a_count != 3'd0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("a_drain", 64'(a_count), 64'd0);
    endtask

    // Scoreboard: compare the head beat whenever the coming edge completes a handshake.
    always @(negedge clk) begin
        if (nrst && a_dm_valid && a_dm_ready) begin
            if (exp_q.size() == 0) begin
                chk("a_unexpected_beat", 64'(a_dm_addr), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                a_e = exp_q.pop_front();
                chk("a_sb_addr", 64'(a_dm_addr), 64'(a_e.addr));
                chk("a_sb_wdata", 64'(a_dm_wdata), 64'(a_e.data));
                chk("a_sb_we", 64'(a_dm_we), 64'(a_e.we));
            end
        end
    end

    initial begin
        nrst = 1'b0;
        a_st_valid = 1'b0; a_st_addr = 32'd0; a_st_data = 32'd0; a_st_size = 2'd0; a_dm_ready = 1'b0;
        b_st_valid = 1'b0; b_st_addr = 32'd0; b_st_data = 32'd0; b_st_size = 2'd0; b_dm_ready = 1'b0;
        c_st_valid = 1'b0; c_st_addr = 32'd0; c_st_data = 64'd0; c_st_size = 2'd0; c_dm_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_count", 64'(a_count), 64'd0);
        chk("rst_dm_valid", 64'(a_dm_valid), 64'd0);
        chk("rst_err", 64'(a_err), 64'd0);
        chk("rst_dm_addr", 64'(a_dm_addr), 64'd0);
        chk("rst_dm_we", 64'(a_dm_we), 64'd0);
        chk("rst_st_ready", 64'(a_st_ready), 64'd1);
        nrst = 1'b1;
        @(posedge clk); #1;

        // sw aligned
        store_a(32'h100, 32'hDEAD_BEEF, 2'd2);
        chk("sw_valid", 64'(a_dm_valid), 64'd1);
        chk("sw_addr", 64'(a_dm_addr), 64'h100);
        chk("sw_wdata", 64'(a_dm_wdata), 64'hDEAD_BEEF);
        chk("sw_we", 64'(a_dm_we), 64'hF);
        chk("sw_count", 64'(a_count), 64'd1);
        a_dm_ready = 1'b1;
        @(posedge clk); #1;
        a_dm_ready = 1'b0;
        chk("sw_drained", 64'(a_dm_valid), 64'd0);

        // sb at lane 3, no bypass on an empty queue
        a_st_valid = 1'b1; a_st_addr = 32'h203; a_st_data = 32'h1234_56AB; a_st_size = 2'd0;
        #2;
        chk("no_bypass", 64'(a_dm_valid), 64'd0);
        push_model(32'h203, 32'h1234_56AB, 2'd0);
        @(posedge clk); #1;
        a_st_valid = 1'b0;
        chk("sb_addr", 64'(a_dm_addr), 64'h200);
        chk("sb_wdata", 64'(a_dm_wdata), 64'hAB00_0000);
        chk("sb_we", 64'(a_dm_we), 64'h8);
        a_dm_ready = 1'b1;
        @(posedge clk); #1;
        a_dm_ready = 1'b0;

        // sh crossing the word boundary
        store_a(32'h303, 32'h0000_CAFE, 2'd1);
        chk("sh_count2", 64'(a_count), 64'd2);
        chk("sh_b0_addr", 64'(a_dm_addr), 64'h300);
        chk("sh_b0_wdata", 64'(a_dm_wdata), 64'hFE00_0000);
        chk("sh_b0_we", 64'(a_dm_we), 64'h8);
        a_dm_ready = 1'b1;
        @(posedge clk); #1;
        chk("sh_b1_addr", 64'(a_dm_addr), 64'h304);
        chk("sh_b1_wdata", 64'(a_dm_wdata), 64'h0000_00CA);
        chk("sh_b1_we", 64'(a_dm_we), 64'h1);
        @(posedge clk); #1;
        chk("sh_count0", 64'(a_count), 64'd0);
        a_dm_ready = 1'b0;

        // Backpressure and stall stability
        store_a(32'h500, 32'h1111_1111, 2'd2);
        store_a(32'h504, 32'h2222_2222, 2'd2);
        chk("bp_count2", 64'(a_count), 64'd2);
        chk("bp_ready2", 64'(a_st_ready), 64'd1);
        store_a(32'h508, 32'h3333_3333, 2'd2);
        chk("bp_count3", 64'(a_count), 64'd3);
        chk("bp_ready3", 64'(a_st_ready), 64'd0);
        a_st_valid = 1'b1; a_st_addr = 32'h50C; a_st_data = 32'h4444_4444; a_st_size = 2'd2;
        repeat (2) @(posedge clk);
        #1;
        chk("stall_count", 64'(a_count), 64'd3);
        chk("stall_addr", 64'(a_dm_addr), 64'h500);
        chk("stall_wdata", 64'(a_dm_wdata), 64'h1111_1111);
        a_dm_ready = 1'b1;
        store_a(32'h50C, 32'h4444_4444, 2'd2);
        drain_a();

        // Pop of the last entry with a same-cycle push
        store_a(32'h600, 32'h6666_6666, 2'd2);
        store_a(32'h604, 32'h7777_7777, 2'd2);
        chk("pp_count", 64'(a_count), 64'd1);
        chk("pp_valid", 64'(a_dm_valid), 64'd1);
        chk("pp_addr", 64'(a_dm_addr), 64'h604);
        drain_a();

        // Random mix under random backpressure
        for (int r = 0; r < 16; r++) begin
            a_dm_ready = (a_count >= 3'd2) ? 1'b1 : 1'($urandom_range(0, 1));
            store_a({20'h0, 4'h9, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))},
                    $urandom, 2'($urandom_range(0, 2)));
        end
        drain_a();
        chk("sb_empty", 64'(exp_q.size()), 64'd0);

        // Double store on a 32-bit queue is dropped
        a_dm_ready = 1'b0;
        a_st_valid = 1'b1; a_st_addr = 32'h700; a_st_data = 32'h5555_5555; a_st_size = 2'd3;
        @(posedge clk); #1;
        a_st_valid = 1'b0;
        chk("sd32_err", 64'(a_err), 64'd1);
        chk("sd32_count", 64'(a_count), 64'd0);
        @(posedge clk); #1;
        chk("sd32_err_pulse", 64'(a_err), 64'd0);

        // No-split instance drops a crossing store
        b_st_valid = 1'b1; b_st_addr = 32'h401; b_st_data = 32'h9999_9999; b_st_size = 2'd2;
        @(posedge clk); #1;
        b_st_valid = 1'b0;
        chk("ns_err", 64'(b_err), 64'd1);
        chk("ns_count", 64'(b_count), 64'd0);
        chk("ns_valid", 64'(b_dm_valid), 64'd0);
        @(posedge clk); #1;
        chk("ns_err_pulse", 64'(b_err), 64'd0);
        chk("ns_valid2", 64'(b_dm_valid), 64'd0);
        b_st_valid = 1'b1; b_st_addr = 32'h403; b_st_data = 32'hFFFF_FF5A; b_st_size = 2'd0;
        @(posedge clk); #1;
        b_st_valid = 1'b0;
        chk("ns_sb_count", 64'(b_count), 64'd1);
        chk("ns_sb_we", 64'(b_dm_we), 64'h8);
        chk("ns_sb_wdata", 64'(b_dm_wdata), 64'h5A00_0000);

        // 64-bit sd at offset 7 splits
        c_st_valid = 1'b1; c_st_addr = 32'h7; c_st_data = 64'h1122_3344_5566_7788; c_st_size = 2'd3;
        @(posedge clk); #1;
        c_st_valid = 1'b0;
        chk("sd64_count", 64'(c_count), 64'd2);
        chk("sd64_b0_addr", 64'(c_dm_addr), 64'h0);
        chk("sd64_b0_we", 64'(c_dm_we), 64'h80);
        chk("sd64_b0_wdata", c_dm_wdata, 64'h8800_0000_0000_0000);
        c_dm_ready = 1'b1;
        @(posedge clk); #1;
        c_dm_ready = 1'b0;
        chk("sd64_b1_addr", 64'(c_dm_addr), 64'h8);
        chk("sd64_b1_we", 64'(c_dm_we), 64'h7F);
        chk("sd64_b1_wdata", c_dm_wdata, 64'h0011_2233_4455_6677);

        // Async reset in the middle of a pending handshake
        a_dm_ready = 1'b0;
        store_a(32'h800, 32'hA0A0_A0A0, 2'd2);
        store_a(32'h804, 32'hB0B0_B0B0, 2'd2);
        store_a(32'h808, 32'hC0C0_C0C0, 2'd2);
        chk("mr_count3", 64'(a_count), 64'd3);
        a_dm_ready = 1'b1;
        #2;
        nrst = 1'b0;
        exp_q.delete();
        #1;
        chk("mr_valid", 64'(a_dm_valid), 64'd0);
        chk("mr_count", 64'(a_count), 64'd0);
        chk("mr_b_count", 64'(b_count), 64'd0);
        chk("mr_c_count", 64'(c_count), 64'd0);
        @(posedge clk); #1;
        nrst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("mr_after_valid", 64'(a_dm_valid), 64'd0);
        chk("mr_after_addr", 64'(a_dm_addr), 64'd0);
        chk("mr_after_err", 64'(a_err), 64'd0);
        chk("sb_final_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
